oflow_mem_write_ctrl: RTL and testbench

OFLOW_MEM_WRITE_CTRL -- requirements
Module: oflow_mem_write_ctrl

---
 rtl/oflow_mem_write_ctrl.sv | 132 +++++++++++++
 tb/tb_oflow_mem_write_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_mem_write_ctrl.sv
// Write-side controller for the optical-flow MEM buffer: steers one frame of bboxes into a
// history slot and records the per-slot bbox count (end pointer) when the frame commits.
module oflow_mem_write_ctrl #(
  parameter int unsigned MAX_HISTORY     = 5,
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned FRAME_NUM_WIDTH = 8,
  parameter int unsigned HIST_WIDTH      = 3
) (
  input  logic                                   clk,
  input  logic                                   reset_N,
  input  logic                                   start_write,
  input  logic [FRAME_NUM_WIDTH-1:0]             frame_num,
  input  logic [HIST_WIDTH-1:0]                  num_of_history_frames,
  input  logic                                   bbox_valid,
  input  logic                                   bbox_last,
  output logic                                   bbox_ready,
  output logic                                   mem_we,
  output logic [HIST_WIDTH-1:0]                  mem_slot,
  output logic [ADDR_WIDTH-1:0]                  mem_offset,
  output logic                                   done_write,
  output logic [MAX_HISTORY*(ADDR_WIDTH+1)-1:0]  end_ptr_flat,
  output logic                                   overflow_err
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] LastIdx = CntW'((2 ** ADDR_WIDTH) - 1);
  localparam logic [HIST_WIDTH-1:0] MaxHist = HIST_WIDTH'(MAX_HISTORY);

  typedef enum logic [1:0] {StIdle, StWrite, StCommit} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [HIST_WIDTH-1:0] slot_q, slot_d;
  logic                  overflow_q, overflow_d;
  logic [ADDR_WIDTH:0]   end_ptr_q [MAX_HISTORY];
  logic [ADDR_WIDTH:0]   end_ptr_d [MAX_HISTORY];

  logic                  handshake;
  logic                  clr_ptr, load_ptr;
  logic [HIST_WIDTH-1:0] n_eff;
  logic [HIST_WIDTH-1:0] slot_new;

  // Fallback depth clamped to 1..MAX_HISTORY so the modulo never divides by zero.
  always_comb begin
    n_eff = num_of_history_frames;
    if (num_of_history_frames == '0) begin
      n_eff = HIST_WIDTH'(1);
    end else if (num_of_history_frames > MaxHist) begin
      n_eff = MaxHist;
    end
    slot_new = HIST_WIDTH'(frame_num % FRAME_NUM_WIDTH'(n_eff));
  end

  assign bbox_ready   = (state_q == StWrite);
  assign handshake    = bbox_valid & bbox_ready;
  assign mem_we       = handshake;
  assign mem_slot     = slot_q;
  assign mem_offset   = cnt_q[ADDR_WIDTH-1:0];
  assign done_write   = (state_q == StCommit);
  assign overflow_err = overflow_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    overflow_d = overflow_q;
    clr_ptr    = 1'b0;
    load_ptr   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_write) begin
          slot_d  = slot_new;
          cnt_d   = '0;
          clr_ptr = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (handshake) begin
          cnt_d = cnt_q + 1'b1;
          if (bbox_last) begin
            state_d = StCommit;
          end else if (cnt_q == LastIdx) begin
            // Slot full: close the frame early and flag the loss.
            state_d    = StCommit;
            overflow_d = 1'b1;
          end
        end
      end
      StCommit: begin
        load_ptr = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    end_ptr_d = end_ptr_q;
    for (int i = 0; i < int'(MAX_HISTORY); i++) begin
      if (clr_ptr && (int'(slot_d) == i)) begin
        end_ptr_d[i] = '0;
      end
      if (load_ptr && (int'(slot_q) == i)) begin
        end_ptr_d[i] = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      slot_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(MAX_HISTORY); i++) begin
        end_ptr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      overflow_q <= overflow_d;
      end_ptr_q  <= end_ptr_d;
    end
  end

  for (genvar g = 0; g < int'(MAX_HISTORY); g++) begin : g_flat
    assign end_ptr_flat[g*CntW +: CntW] = end_ptr_q[g];
  end

endmodule

// File: tb/tb_oflow_mem_write_ctrl.sv
// Bench for oflow_mem_write_ctrl: vector table, directed corner sequences and random traffic
// checked against a frame-level reference model.
module tb_oflow_mem_write_ctrl;

  localparam int MAXH = 5;
  localparam int AW   = 6;
  localparam int CAP  = 64;
  localparam int PW   = AW + 1;

  logic                 clk = 1'b0;
  logic                 reset_N;
  logic                 start_write;
  logic [7:0]           frame_num;
  logic [2:0]           num_of_history_frames;
  logic                 bbox_valid;
  logic                 bbox_last;
  logic                 bbox_ready;
  logic                 mem_we;
  logic [2:0]           mem_slot;
  logic [AW-1:0]        mem_offset;
  logic                 done_write;
  logic [MAXH*PW-1:0]   end_ptr_flat;
  logic                 overflow_err;

  oflow_mem_write_ctrl dut (
    .clk                   (clk),
    .reset_N               (reset_N),
    .start_write           (start_write),
    .frame_num             (frame_num),
    .num_of_history_frames (num_of_history_frames),
    .bbox_valid            (bbox_valid),
    .bbox_last             (bbox_last),
    .bbox_ready            (bbox_ready),
    .mem_we                (mem_we),
    .mem_slot              (mem_slot),
    .mem_offset            (mem_offset),
    .done_write            (done_write),
    .end_ptr_flat          (end_ptr_flat),
    .overflow_err          (overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model, frame level: is a frame open, is a commit due this cycle, bboxes taken.
  bit m_open, m_commit, m_ovf;
  int m_cnt, m_slot;
  int m_ep [MAXH];

  typedef struct {
    int sw; int fn; int nh; int v; int l;
    int e_ready; int e_we; int e_slot; int e_off; int e_done;
    int ep_idx; int ep_val;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ep_of(input int idx);
    return 64'(end_ptr_flat[idx*PW +: PW]);
  endfunction

  task automatic model_reset();
    m_open = 0; m_commit = 0; m_ovf = 0; m_cnt = 0; m_slot = 0;
    for (int i = 0; i < MAXH; i++) m_ep[i] = 0;
  endtask

  task automatic drive(input int sw, input int fn, input int nh, input int v, input int l);
    start_write           = sw[0];
    frame_num             = fn[7:0];
    num_of_history_frames = nh[2:0];
    bbox_valid            = v[0];
    bbox_last             = l[0];
    #1;
  endtask

  task automatic model_check();
    logic [MAXH*PW-1:0] f;
    bit exp_we;
    exp_we = bbox_valid && m_open;
    for (int i = 0; i < MAXH; i++) f[i*PW +: PW] = PW'(m_ep[i]);
    chk("ready", 64'(bbox_ready), 64'(m_open));
    chk("mem_we", 64'(mem_we), 64'(exp_we));
    if (exp_we) begin
      chk("mem_slot", 64'(mem_slot), 64'(m_slot));
      chk("mem_offset", 64'(mem_offset), 64'(m_cnt));
    end
    chk("done_write", 64'(done_write), 64'(m_commit));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    chk("end_ptr_flat", 64'(f), 64'(end_ptr_flat));
  endtask

  // Apply the edge to the model, then advance to just after the next rising edge.
  task automatic model_step();
    int n;
    if (m_commit) begin
      m_ep[m_slot] = m_cnt;
      m_commit = 0;
    end else if (!m_open) begin
      if (start_write) begin
        n = int'(num_of_history_frames);
        if (n < 1) n = 1;
        if (n > MAXH) n = MAXH;
        m_slot = int'(frame_num) % n;
        m_cnt = 0;
        m_ep[m_slot] = 0;
        m_open = 1;
      end
    end else if (bbox_valid) begin
      m_cnt++;
      if (bbox_last) begin
        m_open = 0; m_commit = 1;
      end else if (m_cnt == CAP) begin
        m_open = 0; m_commit = 1; m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input int sw, input int fn, input int nh, input int v, input int l);
    drive(sw, fn, nh, v, l);
    model_check();
    model_step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(bbox_ready), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_done"}, 64'(done_write), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow_err), 64'd0);
    chk({tag, "_slot"}, 64'(mem_slot), 64'd0);
    chk({tag, "_offset"}, 64'(mem_offset), 64'd0);
    chk({tag, "_endptr"}, 64'(end_ptr_flat), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{1, 7, 5, 0, 0,  0, 0, 0, 0, 0,  2, 0};
    tbl[1]  = '{0, 0, 0, 1, 0,  1, 1, 2, 0, 0,  2, 0};
    tbl[2]  = '{0, 0, 0, 1, 0,  1, 1, 2, 1, 0,  2, 0};
    tbl[3]  = '{0, 0, 0, 1, 1,  1, 1, 2, 2, 0,  2, 0};
    tbl[4]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  2, 0};
    tbl[5]  = '{1, 3, 4, 0, 0,  0, 0, 0, 0, 0,  2, 3};
    tbl[6]  = '{0, 0, 0, 1, 0,  1, 1, 3, 0, 0,  3, 0};
    tbl[7]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  3, 0};
    tbl[8]  = '{0, 0, 0, 1, 0,  1, 1, 3, 1, 0,  3, 0};
    tbl[9]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  3, 0};
    tbl[10] = '{0, 0, 0, 1, 0,  1, 1, 3, 2, 0,  3, 0};
    tbl[11] = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  3, 0};
    tbl[12] = '{0, 0, 0, 1, 1,  1, 1, 3, 3, 0,  3, 0};
    tbl[13] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  3, 0};
    tbl[14] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  3, 4};
    tbl[15] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2, 3};

    reset_N = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2;
    chk_all_zero("reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_N = 1'b1;

    // Vector table: three-bbox frame into slot 2, then a gappy four-bbox frame into slot 3.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].sw, tbl[i].fn, tbl[i].nh, tbl[i].v, tbl[i].l);
      chk($sformatf("tbl%0d_ready", i), 64'(bbox_ready), 64'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_we", i), 64'(mem_we), 64'(tbl[i].e_we));
      if (tbl[i].e_we != 0) begin
        chk($sformatf("tbl%0d_slot", i), 64'(mem_slot), 64'(tbl[i].e_slot));
        chk($sformatf("tbl%0d_off", i), 64'(mem_offset), 64'(tbl[i].e_off));
      end
      chk($sformatf("tbl%0d_done", i), 64'(done_write), 64'(tbl[i].e_done));
      chk($sformatf("tbl%0d_ep", i), ep_of(tbl[i].ep_idx), 64'(tbl[i].ep_val));
      model_check();
      model_step();
    end

    // N=0 acts as 1: slot 0; restarting slot 0 clears its pointer until the new commit.
    cycle(1, 9, 0, 0, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0);
    chk("n0_ep0", ep_of(0), 64'd1);
    cycle(1, 10, 5, 0, 0);
    chk("restart_ep0_cleared", ep_of(0), 64'd0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0);
    chk("restart_ep0", ep_of(0), 64'd1);

    // start_write mid-frame and during COMMIT is ignored.
    cycle(1, 6, 4, 0, 0);
    cycle(0, 0, 0, 1, 0);
    drive(1, 1, 4, 1, 0);
    chk("midstart_slot", 64'(mem_slot), 64'd2);
    chk("midstart_off", 64'(mem_offset), 64'd1);
    model_check();
    model_step();
    cycle(1, 3, 5, 1, 0);
    cycle(0, 0, 0, 1, 1);
    drive(1, 1, 4, 0, 0);
    chk("commit_done", 64'(done_write), 64'd1);
    model_check();
    model_step();
    chk("midstart_ep2", ep_of(2), 64'd4);
    chk("midstart_ep1", ep_of(1), 64'd0);
    chk("start_in_commit_ignored", 64'(bbox_ready), 64'd0);
    cycle(0, 0, 0, 0, 0);

    // Reset in the middle of a frame aborts it.
    cycle(1, 1, 5, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    bbox_valid = 1'b1;
    reset_N = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    reset_N = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    chk("midreset_no_done_ep", 64'(end_ptr_flat), 64'd0);

    // Overflow: 65 bboxes without last into slot 4.
    cycle(1, 4, 5, 0, 0);
    for (int i = 0; i < CAP; i++) cycle(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("ovf_65th_ready", 64'(bbox_ready), 64'd0);
    chk("ovf_65th_we", 64'(mem_we), 64'd0);
    chk("ovf_done", 64'(done_write), 64'd1);
    chk("ovf_flag", 64'(overflow_err), 64'd1);
    model_check();
    model_step();
    chk("ovf_ep4", ep_of(4), 64'd64);
    cycle(0, 0, 0, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 5 == 0) ? 1 : 0, int'($urandom % 256), int'($urandom % 8),
            int'($urandom % 4 != 0), ($urandom % 8 == 0) ? 1 : 0);
    end
    chk("ovf_sticky", 64'(overflow_err), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
